// File: rtl/social_energy_arbiter.sv
// Round-robin arbiter that grants fixed-length sessions to four requesters while
// tracking a saturating energy budget that drains in sessions and recovers on retreat.
module social_energy_arbiter #(
  parameter int SESSION_LEN   = 4,
  parameter int MAX_ENERGY    = 15,
  parameter int MIN_START     = 8,
  parameter int DRAIN_KNOWN   = 1,
  parameter int DRAIN_UNKNOWN = 4,
  parameter int RECOVER       = 2,
  parameter int ENERGY_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          invite_req,
  input  logic [3:0]          invite_unknown,
  input  logic                comfort_zone,
  output logic [3:0]          grant,
  output logic [1:0]          out,
  output logic [ENERGY_W-1:0] energy,
  output logic                busy
);

  localparam int CNT_W = (SESSION_LEN > 1) ? $clog2(SESSION_LEN) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(SESSION_LEN - 1);
  localparam logic [ENERGY_W-1:0] MAX_E    = ENERGY_W'(MAX_ENERGY);
  localparam logic [ENERGY_W-1:0] MIN_E    = ENERGY_W'(MIN_START);
  localparam logic [ENERGY_W:0]   MAX_X    = {1'b0, MAX_E};
  localparam logic [ENERGY_W:0]   REC_X    = (ENERGY_W+1)'(RECOVER);
  localparam logic [ENERGY_W:0]   DK_X     = (ENERGY_W+1)'(DRAIN_KNOWN);
  localparam logic [ENERGY_W:0]   DU_X     = (ENERGY_W+1)'(DRAIN_UNKNOWN);

  typedef enum logic [1:0] {S_IDLE, S_SOCIAL, S_DRAINED} state_t;

  state_t              state_q;
  logic [ENERGY_W-1:0] energy_q;
  logic [3:0]          grant_q;
  logic [1:0]          out_q;
  logic [1:0]          last_q;
  logic [1:0]          win_q;
  logic                unk_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [1:0]          win_d;
  logic [ENERGY_W-1:0] rec_d;
  logic [ENERGY_W-1:0] drn_d;
  logic [ENERGY_W:0]   rec_sum;
  logic [ENERGY_W:0]   drain_amt;
  logic [ENERGY_W:0]   drn_diff;

  // Round-robin: walk downward so the requester nearest after last_q wins.
  always_comb begin
    win_d = last_q;
    for (int i = 4; i >= 1; i--) begin
      if (invite_req[2'(last_q + 2'(i))]) win_d = 2'(last_q + 2'(i));
    end
  end

  // Saturating energy arithmetic, evaluated one bit wider so nothing wraps.
  always_comb begin
    rec_sum   = {1'b0, energy_q} + REC_X;
    rec_d     = (rec_sum > MAX_X) ? MAX_E : rec_sum[ENERGY_W-1:0];
    drain_amt = unk_q ? DU_X : DK_X;
    drn_diff  = {1'b0, energy_q} - drain_amt;
    drn_d     = ({1'b0, energy_q} > drain_amt) ? drn_diff[ENERGY_W-1:0] : '0;
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // the asynchronous reset drops grant the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      energy_q <= MAX_E;
      grant_q  <= '0;
      out_q    <= 2'b00;
      last_q   <= 2'd3;
      win_q    <= 2'd0;
      unk_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (comfort_zone) begin
            energy_q <= rec_d;
          end else if ((invite_req != 4'b0) && (energy_q >= MIN_E)) begin
            state_q <= S_SOCIAL;
            grant_q <= 4'b0001 << win_d;
            win_q   <= win_d;
            last_q  <= win_d;
            unk_q   <= invite_unknown[win_d];
            cnt_q   <= CNT_LOAD;
            out_q   <= invite_unknown[win_d] ? 2'b10 : 2'b01;
          end
        end
        S_SOCIAL: begin
          if (!invite_req[win_q]) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            out_q   <= 2'b00;
          end else if (drn_d == '0) begin
            state_q  <= S_DRAINED;
            energy_q <= '0;
            grant_q  <= '0;
            out_q    <= 2'b11;
          end else if (cnt_q == '0) begin
            state_q  <= S_IDLE;
            energy_q <= drn_d;
            grant_q  <= '0;
            out_q    <= 2'b00;
          end else begin
            cnt_q    <= cnt_q - 1'b1;
            energy_q <= drn_d;
          end
        end
        S_DRAINED: begin
          if (comfort_zone) begin
            energy_q <= rec_d;
            if (rec_d >= MIN_E) begin
              state_q <= S_IDLE;
              out_q   <= 2'b00;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          out_q   <= 2'b00;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign out    = out_q;
  assign energy = energy_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_social_energy_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural energy model.
module tb_social_energy_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] invite_req = '0;
  logic [3:0] invite_unknown = '0;
  logic       comfort_zone = 1'b0;
  logic [3:0] grant;
  logic [1:0] out;
  logic [3:0] energy;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Behavioural model: who holds the session, how many drains it has had.
  int m_energy, m_holder, m_drains, m_last;
  bit m_drained, m_unk;

  social_energy_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .invite_req     (invite_req),
    .invite_unknown (invite_unknown),
    .comfort_zone   (comfort_zone),
    .grant          (grant),
    .out            (out),
    .energy         (energy),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_energy = 15; m_holder = -1; m_drains = 0; m_last = 3;
    m_drained = 0; m_unk = 0;
  endtask

  task automatic model_edge();
    if (m_drained) begin
      if (comfort_zone) begin
        m_energy = (m_energy + 2 > 15) ? 15 : m_energy + 2;
        if (m_energy >= 8) m_drained = 0;
      end
    end else if (m_holder >= 0) begin
      if (!invite_req[m_holder]) begin
        m_holder = -1;
      end else begin
        int n;
        n = m_energy - (m_unk ? 4 : 1);
        if (n <= 0) begin
          m_energy = 0; m_holder = -1; m_drained = 1;
        end else begin
          m_energy = n;
          m_drains++;
          if (m_drains == 4) m_holder = -1;
        end
      end
    end else if (comfort_zone) begin
      m_energy = (m_energy + 2 > 15) ? 15 : m_energy + 2;
    end else if (invite_req != 0 && m_energy >= 8) begin
      for (int k = 4; k >= 1; k--) begin
        if (invite_req[(m_last + k) % 4]) m_holder = (m_last + k) % 4;
      end
      m_last = m_holder;
      m_unk = invite_unknown[m_holder];
      m_drains = 0;
    end
  endtask

  task automatic compare_all();
    int eg, eo;
    eg = (m_holder >= 0) ? (1 << m_holder) : 0;
    eo = m_drained ? 3 : (m_holder >= 0) ? (m_unk ? 2 : 1) : 0;
    check("grant",  int'(grant),  eg);
    check("out",    int'(out),    eo);
    check("energy", int'(energy), m_energy);
    check("busy",   int'(busy),   (m_drained || m_holder >= 0) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] u, input logic c);
    invite_req = r; invite_unknown = u; comfort_zone = c;
  endtask

  initial begin
    model_reset();
    do_reset();
    check("reset_energy_lit", int'(energy), 15);
    check("reset_grant_lit",  int'(grant),  0);

    // Single known requester: full session, 15 -> 11.
    set_in(4'b0001, 4'b0000, 1'b0);
    step();
    check("s1_grant_lit", int'(grant), 1);
    check("s1_out_lit",   int'(out),   1);
    repeat (4) step();
    check("s1_end_grant_lit",  int'(grant),  0);
    check("s1_end_energy_lit", int'(energy), 11);
    set_in(4'b0000, 4'b0000, 1'b0);
    step();

    // Two requesters: 0001 then 0100 after one idle cycle, then starved at 7.
    do_reset();
    set_in(4'b0101, 4'b0000, 1'b0);
    repeat (5) step();
    check("rr_idle_gap_lit", int'(grant), 0);
    step();
    check("rr_second_lit", int'(grant), 4);
    repeat (4) step();
    check("rr_energy_lit", int'(energy), 7);
    repeat (2) step();
    check("rr_starved_lit", int'(grant), 0);

    // Unknown requester drains to zero, holds, then recovers to 8.
    do_reset();
    set_in(4'b0010, 4'b0010, 1'b0);
    step();
    check("unk_out_lit", int'(out), 2);
    repeat (4) step();
    check("drained_out_lit",    int'(out),    3);
    check("drained_energy_lit", int'(energy), 0);
    set_in(4'b0000, 4'b0000, 1'b0);
    repeat (2) step();
    check("drained_hold_lit", int'(energy), 0);
    set_in(4'b0000, 4'b0000, 1'b1);
    repeat (3) step();
    check("recover_6_lit", int'(out), 3);
    step();
    check("recover_8_energy_lit", int'(energy), 8);
    check("recover_8_out_lit",    int'(out),    0);

    // Comfort zone blocks grants at energy 14, saturates at 15.
    repeat (3) step();
    check("e14_lit", int'(energy), 14);
    set_in(4'b1000, 4'b0000, 1'b1);
    repeat (2) step();
    check("comfort_grant_lit",  int'(grant),  0);
    check("comfort_energy_lit", int'(energy), 15);

    // Withdrawal: no drain on the exit edge.
    set_in(4'b0001, 4'b0000, 1'b0);
    step(); step();
    set_in(4'b0000, 4'b0000, 1'b0);
    step();
    check("withdraw_grant_lit",  int'(grant),  0);
    check("withdraw_energy_lit", int'(energy), 14);

    // Asynchronous reset mid-session.
    set_in(4'b0100, 4'b0100, 1'b0);
    step(); step();
    #2;
    reset = 1'b1;
    #1;
    check("async_grant_lit",  int'(grant),  0);
    check("async_energy_lit", int'(energy), 15);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) begin
        invite_req = 4'($urandom_range(0, 15));
        invite_unknown = 4'($urandom_range(0, 15));
      end
      comfort_zone = ($urandom_range(0, 4) == 0);
      if (cyc % 700 == 699) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
